// File: rtl/demux1x4_4b_reg.sv
// Registered 1-to-4 demultiplexer that steers one WIDTH-bit word per write into four holding registers.
// Optional macro DEMUX_OVF_EN builds the sticky per-channel overwrite flags; otherwise OVF_o is tied low.
module demux1x4_4b_reg #(
    parameter int WIDTH = 4
) (
    input  logic             CLK_i,
    input  logic             RST_N_i,
    input  logic [WIDTH-1:0] ENT_i,
    input  logic [1:0]       SEL_i,
    input  logic             AUTO_i,
    input  logic             WR_i,
    input  logic [3:0]       ACK_i,
    output logic [WIDTH-1:0] OUT0_o,
    output logic [WIDTH-1:0] OUT1_o,
    output logic [WIDTH-1:0] OUT2_o,
    output logic [WIDTH-1:0] OUT3_o,
    output logic [3:0]       VALID_o,
    output logic [3:0]       OVF_o,
    output logic [1:0]       PTR_o
);

    logic [WIDTH-1:0] r_data [4];
    logic [3:0]       r_valid;
    logic [1:0]       r_ptr;
    logic [1:0]       w_dest;
    logic [3:0]       w_wr;

    assign w_dest = AUTO_i ? r_ptr : SEL_i;
    assign w_wr   = WR_i ? (4'(1) << w_dest) : 4'b0000;

    // A write always wins over an acknowledge to the same channel; acks never touch data.
    always_ff @(posedge CLK_i or negedge RST_N_i) begin
        if (!RST_N_i) begin
            for (int k = 0; k < 4; k++) begin
                r_data[k] <= '0;
            end
            r_valid <= 4'b0000;
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (w_wr[k]) begin
                    r_data[k]  <= ENT_i;
                    r_valid[k] <= 1'b1;
                end else if (ACK_i[k]) begin
                    r_valid[k] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge CLK_i or negedge RST_N_i) begin
        if (!RST_N_i) begin
            r_ptr <= 2'd0;
        end else if (WR_i && AUTO_i) begin
            r_ptr <= r_ptr + 2'd1;
        end
    end

`ifdef DEMUX_OVF_EN
    logic [3:0] r_ovf;

    // Overwriting unconsumed data sets the flag; a same-cycle ack means the old word was consumed.
    always_ff @(posedge CLK_i or negedge RST_N_i) begin
        if (!RST_N_i) begin
            r_ovf <= 4'b0000;
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (w_wr[k]) begin
                    r_ovf[k] <= r_valid[k] & ~ACK_i[k];
                end else if (ACK_i[k]) begin
                    r_ovf[k] <= 1'b0;
                end
            end
        end
    end

    assign OVF_o = r_ovf;
`else
    assign OVF_o = 4'b0000;
`endif

    assign OUT0_o  = r_data[0];
    assign OUT1_o  = r_data[1];
    assign OUT2_o  = r_data[2];
    assign OUT3_o  = r_data[3];
    assign VALID_o = r_valid;
    assign PTR_o   = r_ptr;

endmodule

// File: tb/tb_demux1x4_4b_reg.sv
// Directed self-checking bench for demux1x4_4b_reg; expected OVF values follow DEMUX_OVF_EN.
module tb_demux1x4_4b_reg;

    logic       clk;
    logic       rst_n;
    logic [3:0] ent;
    logic [1:0] sel;
    logic       autoSel;
    logic       wr;
    logic [3:0] ack;
    logic [3:0] out0, out1, out2, out3;
    logic [3:0] valid;
    logic [3:0] ovf;
    logic [1:0] ptr;

    int checkCount = 0;
    int passCount  = 0;

    demux1x4_4b_reg #(.WIDTH(4)) dut (
        .CLK_i   (clk),
        .RST_N_i (rst_n),
        .ENT_i   (ent),
        .SEL_i   (sel),
        .AUTO_i  (autoSel),
        .WR_i    (wr),
        .ACK_i   (ack),
        .OUT0_o  (out0),
        .OUT1_o  (out1),
        .OUT2_o  (out2),
        .OUT3_o  (out3),
        .VALID_o (valid),
        .OVF_o   (ovf),
        .PTR_o   (ptr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef DEMUX_OVF_EN
    localparam logic OVF_ON = 1'b1;
`else
    localparam logic OVF_ON = 1'b0;
`endif

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // One clock with the given inputs, leaving the bench on the following falling edge with inputs idle.
    task automatic applyStimulus(input logic doWr, input logic doAuto, input logic [1:0] s,
                                 input logic [3:0] d, input logic [3:0] a);
        wr      = doWr;
        autoSel = doAuto;
        sel     = s;
        ent     = d;
        ack     = a;
        @(posedge clk);
        @(negedge clk);
        wr  = 1'b0;
        ack = 4'b0000;
    endtask

    task automatic doReset();
        rst_n = 1'b0;
        wr = 1'b0; ack = 4'b0000; autoSel = 1'b0; sel = 2'd0; ent = 4'h0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b1;
        doReset();

        // Reset state
        checkOutput("rst_out0", 32'(out0), 32'h0);
        checkOutput("rst_out3", 32'(out3), 32'h0);
        checkOutput("rst_valid", 32'(valid), 32'h0);
        checkOutput("rst_ovf", 32'(ovf), 32'h0);
        checkOutput("rst_ptr", 32'(ptr), 32'h0);

        // Explicit select write to channel 2
        applyStimulus(1'b1, 1'b0, 2'd2, 4'hA, 4'b0000);
        checkOutput("sel_out2", 32'(out2), 32'hA);
        checkOutput("sel_valid", 32'(valid), 32'b0100);
        checkOutput("sel_ptr", 32'(ptr), 32'h0);
        checkOutput("sel_others", 32'({out0, out1, out3}), 32'h0);
        checkOutput("sel_ovf", 32'(ovf), 32'h0);

        // Idle cycle with garbage on SEL/ENT/AUTO must change nothing
        applyStimulus(1'b0, 1'b1, 2'd1, 4'hF, 4'b0000);
        checkOutput("idle_out1", 32'(out1), 32'h0);
        checkOutput("idle_ptr", 32'(ptr), 32'h0);
        checkOutput("idle_valid", 32'(valid), 32'b0100);

        // Ack to an empty channel is harmless; ack to channel 2 keeps its data
        applyStimulus(1'b0, 1'b0, 2'd0, 4'h0, 4'b0101);
        checkOutput("ackempty_valid", 32'(valid), 32'b0000);
        checkOutput("ackempty_out2", 32'(out2), 32'hA);

        // Round-robin: five auto writes wrap the pointer and overwrite channel 0
        doReset();
        for (int i = 1; i <= 5; i++) begin
            applyStimulus(1'b1, 1'b1, 2'd3, 4'(i), 4'b0000);
        end
        checkOutput("rr_out0", 32'(out0), 32'h5);
        checkOutput("rr_out1", 32'(out1), 32'h2);
        checkOutput("rr_out2", 32'(out2), 32'h3);
        checkOutput("rr_out3", 32'(out3), 32'h4);
        checkOutput("rr_valid", 32'(valid), 32'b1111);
        checkOutput("rr_ptr", 32'(ptr), 32'h1);
        checkOutput("rr_ovf", 32'(ovf), OVF_ON ? 32'b0001 : 32'b0000);

        // Explicit write does not move the pointer
        applyStimulus(1'b1, 1'b0, 2'd0, 4'h6, 4'b0000);
        checkOutput("man_ptr", 32'(ptr), 32'h1);

        // Write and ack on the same channel: write wins, overflow cleared
        doReset();
        applyStimulus(1'b1, 1'b0, 2'd1, 4'h3, 4'b0000);
        applyStimulus(1'b1, 1'b0, 2'd1, 4'h7, 4'b0010);
        checkOutput("wack_out1", 32'(out1), 32'h7);
        checkOutput("wack_valid1", 32'(valid[1]), 32'h1);
        checkOutput("wack_ovf1", 32'(ovf[1]), 32'h0);
        applyStimulus(1'b0, 1'b0, 2'd0, 4'h0, 4'b0010);
        checkOutput("ack_valid1", 32'(valid[1]), 32'h0);
        checkOutput("ack_out1", 32'(out1), 32'h7);

        // Overwrite channel 3 twice, then consume it
        doReset();
        applyStimulus(1'b1, 1'b0, 2'd3, 4'h1, 4'b0000);
        applyStimulus(1'b1, 1'b0, 2'd3, 4'h2, 4'b0000);
        checkOutput("ow_ovf", 32'(ovf), OVF_ON ? 32'b1000 : 32'b0000);
        checkOutput("ow_out3", 32'(out3), 32'h2);
        applyStimulus(1'b0, 1'b0, 2'd0, 4'h0, 4'b1000);
        checkOutput("owack_valid3", 32'(valid[3]), 32'h0);
        checkOutput("owack_ovf3", 32'(ovf[3]), 32'h0);

        // Fill all, then asynchronous reset between edges
        doReset();
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 1'b1, 2'd0, 4'(8 + i), 4'b0000);
        end
        checkOutput("fill_valid", 32'(valid), 32'b1111);
        checkOutput("fill_ptr", 32'(ptr), 32'h0);
        checkOutput("fill_out3", 32'(out3), 32'hB);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("arst_outs", 32'({out0, out1, out2, out3}), 32'h0);
        checkOutput("arst_valid", 32'(valid), 32'h0);
        checkOutput("arst_ovf", 32'(ovf), 32'h0);
        checkOutput("arst_ptr", 32'(ptr), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(1'b1, 1'b1, 2'd2, 4'h9, 4'b0000);
        checkOutput("post_out0", 32'(out0), 32'h9);
        checkOutput("post_valid", 32'(valid), 32'b0001);
        checkOutput("post_ptr", 32'(ptr), 32'h1);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
